display_arbiter: RTL and testbench

- Shares the single 8-tube seven-segment display (digit1/digit2/tube_sel) among four display sources.
- Source 0 is the base view (current time) and drives the tubes whenever no overlay is active.
- Sources 1..3 (self-clean countdown, smoker/accumulated-time view, gesture-time view; priority 1 lowest, 3 highest) each request a timed overlay.
- The block schedules overlays by fixed priority with preemption, queues lower-priority requests, and blanks the display when the machine is off.

---
 rtl/display_arbiter.sv | 176 +++++++++++++++++
 tb/tb_display_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - priority/preemption arbiter sharing the seven-segment display
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   machine_state  1 = on; 0 = display blanked, scheduler flushed
//   src_req[3:0]   per-source overlay request pulses (bit 0 unused, source 0 is the base view)
//   src_digit1     source k digit1 segments in [8k+7:8k]
//   src_digit2     source k digit2 segments in [8k+7:8k]
//   src_tube_sel   source k tube-select in [8k+7:8k]
//   digit1/digit2  registered segment buses
//   tube_sel       registered tube-select
//   active_src     source currently driving the outputs
//   busy           an overlay (source 1..3) holds the display
module display_arbiter #(
   parameter int HOLD_CYCLES = 100000000,
   parameter int CNT_W       = 27
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        machine_state,
   input  logic [3:0]  src_req,
   input  logic [31:0] src_digit1,
   input  logic [31:0] src_digit2,
   input  logic [31:0] src_tube_sel,
   output logic [7:0]  digit1,
   output logic [7:0]  digit2,
   output logic [7:0]  tube_sel,
   output logic [1:0]  active_src,
   output logic        busy
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       cur_nxt;
   logic [3:1]       pending;
   logic [3:1]       pending_nxt;
   logic [CNT_W-1:0] timer;
   logic [CNT_W-1:0] timer_nxt;
   logic [3:1]       eff_req;
   logic [3:1]       cur_mask;
   logic [3:1]       above;
   logic [4:0]       sel_base;
   logic             unused_req0;

   assign unused_req0 = src_req[0];

   function automatic logic [1:0] top_idx(input logic [3:1] v);
      logic [1:0] r;
      if (v[3])      r = 2'd3;
      else if (v[2]) r = 2'd2;
      else if (v[1]) r = 2'd1;
      else           r = 2'd0;
      return r;
   endfunction

   function automatic logic [3:1] idx_mask(input logic [1:0] i);
      logic [3:1] m;
      case (i)
         2'd1:    m = 3'b001;
         2'd2:    m = 3'b010;
         2'd3:    m = 3'b100;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

   // Bits strictly above index i: the sources allowed to preempt it.
   function automatic logic [3:1] above_mask(input logic [1:0] i);
      logic [3:1] m;
      case (i)
         2'd0:    m = 3'b111;
         2'd1:    m = 3'b110;
         2'd2:    m = 3'b100;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

   always_comb begin
      state_nxt   = state;
      cur_nxt     = active_src;
      pending_nxt = pending;
      timer_nxt   = timer;
      eff_req     = pending | src_req[3:1];
      cur_mask    = idx_mask(active_src);
      above       = eff_req & above_mask(active_src);

      if (!machine_state) begin
         state_nxt   = IDLE;
         cur_nxt     = 2'd0;
         pending_nxt = 3'b000;
         timer_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (eff_req != 3'b000) begin
                  cur_nxt     = top_idx(eff_req);
                  pending_nxt = eff_req & ~idx_mask(cur_nxt);
                  timer_nxt   = RELOAD;
                  state_nxt   = HOLD;
               end
            end
            HOLD: begin
               if (above != 3'b000) begin
                  // Preempted source is dropped rather than re-queued.
                  cur_nxt     = top_idx(above);
                  pending_nxt = eff_req & ~idx_mask(cur_nxt) & ~cur_mask;
                  timer_nxt   = RELOAD;
               end else if (src_req[active_src]) begin
                  pending_nxt = eff_req & ~cur_mask;
                  timer_nxt   = RELOAD;
               end else if (timer == '0) begin
                  if (eff_req != 3'b000) begin
                     cur_nxt     = top_idx(eff_req);
                     pending_nxt = eff_req & ~idx_mask(cur_nxt);
                     timer_nxt   = RELOAD;
                  end else begin
                     cur_nxt     = 2'd0;
                     pending_nxt = 3'b000;
                     state_nxt   = IDLE;
                  end
               end else begin
                  // Only lower-priority bits can be set here; they wait.
                  pending_nxt = eff_req;
                  timer_nxt   = timer - CNT_W'(1);
               end
            end
            default: begin
               state_nxt   = IDLE;
               cur_nxt     = 2'd0;
               pending_nxt = 3'b000;
               timer_nxt   = '0;
            end
         endcase
      end
   end

   assign sel_base = {cur_nxt, 3'b000};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         active_src <= 2'd0;
         busy       <= 1'b0;
         pending    <= 3'b000;
         timer      <= '0;
         digit1     <= 8'h00;
         digit2     <= 8'h00;
         tube_sel   <= 8'h00;
      end else begin
         state      <= state_nxt;
         active_src <= cur_nxt;
         busy       <= (state_nxt == HOLD);
         pending    <= pending_nxt;
         timer      <= timer_nxt;
         if (machine_state) begin
            digit1   <= src_digit1[sel_base +: 8];
            digit2   <= src_digit2[sel_base +: 8];
            tube_sel <= src_tube_sel[sel_base +: 8];
         end else begin
            digit1   <= 8'h00;
            digit2   <= 8'h00;
            tube_sel <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - scoreboard bench for display_arbiter
module tb_display_arbiter;

   logic        clk;
   logic        rst;
   logic        machine_state;
   logic [3:0]  src_req;
   logic [31:0] src_digit1;
   logic [31:0] src_digit2;
   logic [31:0] src_tube_sel;
   logic [7:0]  digit1;
   logic [7:0]  digit2;
   logic [7:0]  tube_sel;
   logic [1:0]  active_src;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;
   int sc_id    = -1;
   int cyc_id   = 0;

   typedef struct {
      int         src;   // 0..3 shown source, 4 = blanked
      logic [7:0] d1;
      logic [7:0] d2;
      logic [7:0] ts;
   } exp_t;

   exp_t sb[$];

   display_arbiter #(
      .HOLD_CYCLES(8),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .machine_state(machine_state),
      .src_req(src_req),
      .src_digit1(src_digit1),
      .src_digit2(src_digit2),
      .src_tube_sel(src_tube_sel),
      .digit1(digit1),
      .digit2(digit2),
      .tube_sel(tube_sel),
      .active_src(active_src),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s scen=%0d cycle=%0d got=0x%0h exp=0x%0h", tag, sc_id, cyc_id, got, exp);
      end
   endtask

   function automatic logic [3:0] req_for(input int sc, input int c);
      logic [3:0] r;
      r = 4'b0000;
      case (sc)
         0: begin
            if (c == 5)  r = 4'b0001;
            if (c == 10) r = 4'b0100;
         end
         1: begin
            if (c == 10) r = 4'b0010;
            if (c == 13) r = 4'b1000;
         end
         2: begin
            if (c == 10) r = 4'b1000;
            if (c == 12) r = 4'b0010;
         end
         3: if (c == 10 || c == 15) r = 4'b0100;
         4: begin
            if (c == 10) r = 4'b0100;
            if (c == 14) r = 4'b1000;
         end
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

   function automatic logic ms_for(input int sc, input int c);
      return !(sc == 4 && c >= 13 && c <= 15);
   endfunction

   // Expected source shown in output cycle c, written from the timeline of each case.
   function automatic int exp_src(input int sc, input int c);
      int s;
      s = 0;
      case (sc)
         0: if (c >= 11 && c <= 18) s = 2;
         1: begin
            if (c >= 11 && c <= 13) s = 1;
            if (c >= 14 && c <= 21) s = 3;
         end
         2: begin
            if (c >= 11 && c <= 18) s = 3;
            if (c >= 19 && c <= 26) s = 1;
         end
         3: if (c >= 11 && c <= 23) s = 2;
         4: begin
            if (c >= 11 && c <= 13) s = 2;
            if (c >= 14 && c <= 16) s = 4;
         end
         default: s = 0;
      endcase
      return s;
   endfunction

   task automatic compare_outputs(input exp_t e);
      logic [1:0] ea;
      logic       eb;
      ea = (e.src == 4) ? 2'd0 : 2'(e.src);
      eb = (e.src >= 1 && e.src <= 3);
      check("active_src", 32'(active_src), 32'(ea));
      check("busy", 32'(busy), 32'(eb));
      check("digit1", 32'(digit1), 32'(e.d1));
      check("digit2", 32'(digit2), 32'(e.d2));
      check("tube_sel", 32'(tube_sel), 32'(e.ts));
   endtask

   initial begin
      exp_t e;
      exp_t got_e;
      rst           = 1'b0;
      machine_state = 1'b1;
      src_req       = 4'b0000;
      src_digit1    = 32'h0000_003F;
      src_digit2    = 32'h0000_0006;
      src_tube_sel  = 32'h0000_0001;

      // Reset holds everything at zero.
      repeat (3) begin
         @(posedge clk);
         #1;
         check("rst_digit1", 32'(digit1), 32'h00);
         check("rst_digit2", 32'(digit2), 32'h00);
         check("rst_tube_sel", 32'(tube_sel), 32'h00);
         check("rst_active", 32'(active_src), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
      end
      rst = 1'b1;
      check("pre_edge_digit1", 32'(digit1), 32'h00);
      @(posedge clk);
      #1;
      check("first_digit1", 32'(digit1), 32'h3F);
      check("first_digit2", 32'(digit2), 32'h06);
      check("first_tube_sel", 32'(tube_sel), 32'h01);
      check("first_active", 32'(active_src), 32'd0);
      check("first_busy", 32'(busy), 32'd0);

      for (int sc = 0; sc < 5; sc++) begin
         sc_id = sc;
         sb.delete();
         for (int c = 0; c <= 30; c++) begin
            @(posedge clk);
            #1;
            cyc_id = c;
            if (c > 0) begin
               if (sb.size() == 0) begin
                  check("sb_empty", 32'd0, 32'd1);
               end else begin
                  got_e = sb.pop_front();
                  compare_outputs(got_e);
               end
            end
            if (c < 30) begin
               src_req       = req_for(sc, c);
               machine_state = ms_for(sc, c);
               src_digit1    = $urandom;
               src_digit2    = $urandom;
               src_tube_sel  = $urandom;
               e.src = exp_src(sc, c + 1);
               if (e.src == 4) begin
                  e.d1 = 8'h00;
                  e.d2 = 8'h00;
                  e.ts = 8'h00;
               end else begin
                  e.d1 = src_digit1[8*e.src +: 8];
                  e.d2 = src_digit2[8*e.src +: 8];
                  e.ts = src_tube_sel[8*e.src +: 8];
               end
               sb.push_back(e);
            end else begin
               src_req       = 4'b0000;
               machine_state = 1'b1;
            end
         end
         check("sb_drained", 32'(sb.size()), 32'd0);
      end

      // Asynchronous reset in the middle of an overlay.
      sc_id        = 5;
      cyc_id       = 0;
      src_digit1   = 32'h4466_2211;
      src_digit2   = 32'h5577_3322;
      src_tube_sel = 32'h8040_2010;
      @(posedge clk);
      #1;
      src_req = 4'b0100;
      @(posedge clk);
      #1;
      src_req = 4'b0000;
      check("mid_busy", 32'(busy), 32'd1);
      check("mid_active", 32'(active_src), 32'd2);
      check("mid_digit1", 32'(digit1), 32'h66);
      #2;
      rst = 1'b0;
      #1;
      check("async_busy", 32'(busy), 32'd0);
      check("async_active", 32'(active_src), 32'd0);
      check("async_digit1", 32'(digit1), 32'h00);
      check("async_tube_sel", 32'(tube_sel), 32'h00);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         cyc_id = k;
         check("post_rst_active", 32'(active_src), 32'd0);
         check("post_rst_busy", 32'(busy), 32'd0);
         check("post_rst_digit1", 32'(digit1), 32'h11);
         check("post_rst_digit2", 32'(digit2), 32'h22);
         check("post_rst_tube_sel", 32'(tube_sel), 32'h10);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
